// File: rtl/evg_pkg.sv
// Shared definitions for the EVG event-code path.
//   EVENTCODE_WIDTH   width of an event code on the transmit stream
//   EVCODE_IDLE       code sent when nothing is scheduled
//   EVCODE_HEARTBEAT  default heartbeat code
//   evgSource_t       arbitration source index (HB is highest priority)
//   isContended()     true when two or more sources are pending in a slot
package evg_pkg;

  localparam int EVENTCODE_WIDTH = 8;

  localparam logic [EVENTCODE_WIDTH-1:0] EVCODE_IDLE      = '0;
  localparam logic [EVENTCODE_WIDTH-1:0] EVCODE_HEARTBEAT = 8'h7A;

  typedef enum logic [1:0] {
    HB  = 2'd0,
    SEQ = 2'd1,
    HW  = 2'd2,
    SW  = 2'd3
  } evgSource_t;

  // pending is indexed by evgSource_t
  function automatic logic isContended(input logic [3:0] pending);
    return ($countones(pending) >= 2);
  endfunction

endpackage

// File: rtl/evg_event_holding_reg.sv
// One-entry holding register for an event-code request stream.
// Ports:
//   clk     transmitter clock
//   reset   synchronous active-high reset; empties the register
//   TDATA   requested event code
//   TVALID  request valid
//   TREADY  request accepted (register empty and not in reset)
//   full    register holds a code awaiting a transmit slot
//   code    held code
//   grant   arbiter has taken the held code this cycle
module evg_event_holding_reg
  import evg_pkg::*;
#(
  parameter int W = EVENTCODE_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] TDATA,
  input  logic         TVALID,
  output logic         TREADY,
  output logic         full,
  output logic [W-1:0] code,
  input  logic         grant
);

  // Derived from registered state and reset only, never from TVALID.
  assign TREADY = !full && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      code <= '0;
    end else if (grant) begin
      full <= 1'b0;
      code <= '0;
    end else if (TVALID && TREADY && (TDATA != W'(EVCODE_IDLE))) begin
      // an idle code is acknowledged but never scheduled
      full <= 1'b1;
      code <= TDATA;
    end
  end

endmodule

// File: rtl/evg_event_arbiter.sv
// Merges sequencer, hardware-trigger and software event-code requests plus
// a periodic heartbeat into the single code stream of the EVG transmitter.
// One code is inserted per transmit slot, fixed priority HB > SEQ > HW > SW.
// Ports:
//   evgTxClk, evgTxReset        clock, synchronous active-high reset
//   evgTxSlot                   transmitter takes a code this cycle
//   heartbeatEnable             enables heartbeat insertion
//   countClear                  clears contentionCount
//   seqEvent*/hwEvent*/swEvent* TDATA/TVALID/TREADY request streams
//   evgTxCode, evgTxCodeValid   registered code and its one-cycle valid
//   evgTxHeartbeat              pulse when the emitted code is the heartbeat
//   contentionCount             saturating count of contended slots
module evg_event_arbiter
  import evg_pkg::*;
#(
  parameter int                         EVENTCODE_WIDTH    = evg_pkg::EVENTCODE_WIDTH,
  parameter logic [EVENTCODE_WIDTH-1:0] HEARTBEAT_CODE     = EVCODE_HEARTBEAT,
  parameter logic [31:0]                HEARTBEAT_INTERVAL = 32'd125000000
) (
  input  logic                       evgTxClk,
  input  logic                       evgTxReset,
  input  logic                       evgTxSlot,
  input  logic                       heartbeatEnable,
  input  logic                       countClear,
  input  logic [EVENTCODE_WIDTH-1:0] seqEventTDATA,
  input  logic                       seqEventTVALID,
  output logic                       seqEventTREADY,
  input  logic [EVENTCODE_WIDTH-1:0] hwEventTDATA,
  input  logic                       hwEventTVALID,
  output logic                       hwEventTREADY,
  input  logic [EVENTCODE_WIDTH-1:0] swEventTDATA,
  input  logic                       swEventTVALID,
  output logic                       swEventTREADY,
  output logic [EVENTCODE_WIDTH-1:0] evgTxCode,
  output logic                       evgTxCodeValid,
  output logic                       evgTxHeartbeat,
  output logic [15:0]                contentionCount
);

  logic                       seqFull, hwFull, swFull;
  logic [EVENTCODE_WIDTH-1:0] seqCode, hwCode, swCode;
  logic                       seqGrant, hwGrant, swGrant, hbGrant;

  logic [31:0]                hbCount;
  logic                       hbPending;
  logic                       hbWrap;

  evgSource_t                 winner;
  logic                       anyPending;
  logic [EVENTCODE_WIDTH-1:0] winnerCode;
  logic [3:0]                 pendingVec;

  evg_event_holding_reg #(.W(EVENTCODE_WIDTH)) seqReg (
    .clk(evgTxClk), .reset(evgTxReset),
    .TDATA(seqEventTDATA), .TVALID(seqEventTVALID), .TREADY(seqEventTREADY),
    .full(seqFull), .code(seqCode), .grant(seqGrant)
  );

  evg_event_holding_reg #(.W(EVENTCODE_WIDTH)) hwReg (
    .clk(evgTxClk), .reset(evgTxReset),
    .TDATA(hwEventTDATA), .TVALID(hwEventTVALID), .TREADY(hwEventTREADY),
    .full(hwFull), .code(hwCode), .grant(hwGrant)
  );

  evg_event_holding_reg #(.W(EVENTCODE_WIDTH)) swReg (
    .clk(evgTxClk), .reset(evgTxReset),
    .TDATA(swEventTDATA), .TVALID(swEventTVALID), .TREADY(swEventTREADY),
    .full(swFull), .code(swCode), .grant(swGrant)
  );

  always_comb begin
    pendingVec = '0;
    pendingVec[HB]  = hbPending;
    pendingVec[SEQ] = seqFull;
    pendingVec[HW]  = hwFull;
    pendingVec[SW]  = swFull;

    winner     = HB;
    anyPending = 1'b1;
    winnerCode = HEARTBEAT_CODE;
    if (hbPending) begin
      winner     = HB;
      winnerCode = HEARTBEAT_CODE;
    end else if (seqFull) begin
      winner     = SEQ;
      winnerCode = seqCode;
    end else if (hwFull) begin
      winner     = HW;
      winnerCode = hwCode;
    end else if (swFull) begin
      winner     = SW;
      winnerCode = swCode;
    end else begin
      anyPending = 1'b0;
      winnerCode = EVENTCODE_WIDTH'(EVCODE_IDLE);
    end

    hbGrant  = evgTxSlot && anyPending && (winner == HB);
    seqGrant = evgTxSlot && anyPending && (winner == SEQ);
    hwGrant  = evgTxSlot && anyPending && (winner == HW);
    swGrant  = evgTxSlot && anyPending && (winner == SW);
  end

  assign hbWrap = (hbCount == (HEARTBEAT_INTERVAL - 32'd1));

  always_ff @(posedge evgTxClk) begin
    if (evgTxReset) begin
      evgTxCode       <= '0;
      evgTxCodeValid  <= 1'b0;
      evgTxHeartbeat  <= 1'b0;
      hbCount         <= '0;
      hbPending       <= 1'b0;
      contentionCount <= '0;
    end else begin
      evgTxCode      <= '0;
      evgTxCodeValid <= 1'b0;
      evgTxHeartbeat <= 1'b0;
      if (evgTxSlot && anyPending) begin
        evgTxCode      <= winnerCode;
        evgTxCodeValid <= 1'b1;
        evgTxHeartbeat <= hbGrant;
      end

      if (!heartbeatEnable) begin
        hbCount   <= '0;
        hbPending <= 1'b0;
      end else begin
        if (hbGrant) hbPending <= 1'b0;
        // a wrap in the granting slot re-arms the heartbeat for a later slot
        if (evgTxSlot) begin
          if (hbWrap) begin
            hbCount   <= '0;
            hbPending <= 1'b1;
          end else begin
            hbCount <= hbCount + 32'd1;
          end
        end
      end

      if (countClear) begin
        contentionCount <= '0;
      end else if (evgTxSlot && isContended(pendingVec) && (contentionCount != 16'hFFFF)) begin
        contentionCount <= contentionCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_evg_event_arbiter.sv
// Self-checking bench for evg_event_arbiter. Expected codes are queued when
// requests are driven and popped by a monitor when the DUT emits a code.
module tb_evg_event_arbiter;

  logic        evgTxClk = 1'b0;
  logic        evgTxReset;
  logic        evgTxSlot;
  logic        heartbeatEnable;
  logic        countClear;
  logic [7:0]  seqEventTDATA, hwEventTDATA, swEventTDATA;
  logic        seqEventTVALID, hwEventTVALID, swEventTVALID;
  logic        seqEventTREADY, hwEventTREADY, swEventTREADY;
  logic [7:0]  evgTxCode;
  logic        evgTxCodeValid;
  logic        evgTxHeartbeat;
  logic [15:0] contentionCount;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  expQ[$];
  logic [8:0]  monExp;
  bit          monOn = 1'b0;

  always #5 evgTxClk = ~evgTxClk;

  evg_event_arbiter #(.HEARTBEAT_INTERVAL(32'd4)) dut (
    .evgTxClk(evgTxClk),
    .evgTxReset(evgTxReset),
    .evgTxSlot(evgTxSlot),
    .heartbeatEnable(heartbeatEnable),
    .countClear(countClear),
    .seqEventTDATA(seqEventTDATA),
    .seqEventTVALID(seqEventTVALID),
    .seqEventTREADY(seqEventTREADY),
    .hwEventTDATA(hwEventTDATA),
    .hwEventTVALID(hwEventTVALID),
    .hwEventTREADY(hwEventTREADY),
    .swEventTDATA(swEventTDATA),
    .swEventTVALID(swEventTVALID),
    .swEventTREADY(swEventTREADY),
    .evgTxCode(evgTxCode),
    .evgTxCodeValid(evgTxCodeValid),
    .evgTxHeartbeat(evgTxHeartbeat),
    .contentionCount(contentionCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge evgTxClk);
    #1;
  endtask

  // {heartbeat, code} of every emitted code must match the queue head
  always @(negedge evgTxClk) begin
    if (monOn) begin
      if (evgTxCodeValid) begin
        if (expQ.size() == 0) begin
          chk("unexpected_code", {23'd0, evgTxHeartbeat, evgTxCode}, 32'd0);
        end else begin
          monExp = expQ.pop_front();
          chk("tx_code", {23'd0, evgTxHeartbeat, evgTxCode}, {23'd0, monExp});
        end
      end else begin
        chk("idle_out", {23'd0, evgTxHeartbeat, evgTxCode}, 32'd0);
      end
    end
  end

  initial begin
    evgTxReset      = 1'b1;
    evgTxSlot       = 1'b0;
    heartbeatEnable = 1'b0;
    countClear      = 1'b0;
    seqEventTDATA   = 8'h00; seqEventTVALID = 1'b0;
    hwEventTDATA    = 8'h00; hwEventTVALID  = 1'b0;
    swEventTDATA    = 8'h00; swEventTVALID  = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_ready", {29'd0, seqEventTREADY, hwEventTREADY, swEventTREADY}, 32'd0);
    chk("rst_outputs", {7'd0, evgTxCodeValid, evgTxHeartbeat, evgTxCode, contentionCount}, 32'd0);
    evgTxReset = 1'b0;
    #1;
    chk("post_rst_ready", {29'd0, seqEventTREADY, hwEventTREADY, swEventTREADY}, 32'd7);
    monOn = 1'b1;

    // single hw code, slots every cycle: output at t+2, TREADY low only at t+1
    evgTxSlot     = 1'b1;
    hwEventTDATA  = 8'h21;
    hwEventTVALID = 1'b1;
    expQ.push_back(9'h021);
    chk("t1_ready_t", hwEventTREADY, 1);
    tick();
    hwEventTVALID = 1'b0;
    chk("t1_ready_t1", hwEventTREADY, 0);
    chk("t1_valid_t1", evgTxCodeValid, 0);
    tick();
    chk("t1_valid_t2", evgTxCodeValid, 1);
    chk("t1_code_t2", evgTxCode, 8'h21);
    chk("t1_ready_t2", hwEventTREADY, 1);
    tick();
    chk("t1_valid_t3", evgTxCodeValid, 0);

    // simultaneous seq/hw/sw, slots every 2nd cycle
    evgTxSlot  = 1'b0;
    countClear = 1'b1;
    tick();
    countClear = 1'b0;
    seqEventTDATA = 8'h10; seqEventTVALID = 1'b1;
    hwEventTDATA  = 8'h20; hwEventTVALID  = 1'b1;
    swEventTDATA  = 8'h30; swEventTVALID  = 1'b1;
    expQ.push_back(9'h010);
    expQ.push_back(9'h020);
    expQ.push_back(9'h030);
    tick();
    seqEventTVALID = 1'b0; hwEventTVALID = 1'b0; swEventTVALID = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      evgTxSlot = i[0];
      tick();
    end
    evgTxSlot = 1'b0;
    tick();
    chk("t2_contention", contentionCount, 2);
    chk("t2_drained", expQ.size(), 0);

    // zero code is acknowledged and dropped
    evgTxSlot     = 1'b1;
    swEventTDATA  = 8'h00;
    swEventTVALID = 1'b1;
    repeat (3) begin
      chk("zero_ready", swEventTREADY, 1);
      tick();
    end
    swEventTVALID = 1'b0;
    repeat (3) begin
      chk("zero_valid", evgTxCodeValid, 0);
      tick();
    end

    // heartbeat every 4 slots; seq waits behind a coincident heartbeat
    heartbeatEnable = 1'b1;
    repeat (3) expQ.push_back(9'h17A);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 15) begin
        seqEventTDATA  = 8'h44;
        seqEventTVALID = 1'b1;
        expQ.push_back(9'h17A);
        expQ.push_back(9'h044);
      end
      if (k == 16) seqEventTVALID = 1'b0;
      if (k == 18) heartbeatEnable = 1'b0;
      chk("hb_pulse", evgTxHeartbeat, (k == 5 || k == 9 || k == 13 || k == 17));
      if (k == 17) chk("hb_code", evgTxCode, 8'h7A);
      if (k == 18) chk("hb_seq_after", evgTxCode, 8'h44);
    end
    repeat (6) tick();
    chk("hb_drained", expQ.size(), 0);

    // reset mid-operation with all registers full
    evgTxSlot = 1'b0;
    seqEventTDATA = 8'h51; seqEventTVALID = 1'b1;
    hwEventTDATA  = 8'h52; hwEventTVALID  = 1'b1;
    swEventTDATA  = 8'h53; swEventTVALID  = 1'b1;
    tick();
    seqEventTVALID = 1'b0; hwEventTVALID = 1'b0; swEventTVALID = 1'b0;
    chk("pre_rst_count", contentionCount, 3);
    evgTxReset = 1'b1;
    #1;
    chk("mid_rst_ready", {29'd0, seqEventTREADY, hwEventTREADY, swEventTREADY}, 32'd0);
    tick();
    evgTxReset = 1'b0;
    #1;
    chk("after_rst_ready", {29'd0, seqEventTREADY, hwEventTREADY, swEventTREADY}, 32'd7);
    chk("after_rst_count", contentionCount, 0);
    evgTxSlot = 1'b1;
    repeat (4) begin
      tick();
      chk("after_rst_novalid", evgTxCodeValid, 0);
    end

    // saturation: every slot contended, seq and hw alternate while sw waits
    evgTxSlot  = 1'b0;
    countClear = 1'b1;
    tick();
    countClear = 1'b0;
    seqEventTDATA = 8'h61; seqEventTVALID = 1'b1;
    hwEventTDATA  = 8'h62; hwEventTVALID  = 1'b1;
    swEventTDATA  = 8'h63; swEventTVALID  = 1'b1;
    tick();
    for (int j = 0; j < 65540; j++) begin
      evgTxSlot = 1'b1;
      expQ.push_back(j[0] ? 9'h062 : 9'h061);
      if (j == 65534) chk("sat_fffe", contentionCount, 16'hFFFE);
      if (j == 65535) chk("sat_ffff", contentionCount, 16'hFFFF);
      if (j == 65539) chk("sat_hold", contentionCount, 16'hFFFF);
      tick();
    end
    seqEventTVALID = 1'b0; hwEventTVALID = 1'b0; swEventTVALID = 1'b0;
    // seq and sw remain: a contended slot coincident with countClear
    countClear = 1'b1;
    expQ.push_back(9'h061);
    tick();
    countClear = 1'b0;
    chk("clear_on_contended", contentionCount, 0);
    expQ.push_back(9'h063);
    tick();
    evgTxSlot = 1'b0;
    chk("clear_then_single", contentionCount, 0);
    repeat (3) tick();
    chk("sat_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
